// File: rtl/alu_ctrl_pkg.sv
// Shared types and codes for the alu_system hardwired control unit.
package alu_ctrl_pkg;

  localparam int unsigned OPW    = 6;
  localparam int unsigned STEP_W = 3;

  typedef enum logic [2:0] {
    CLR_PC  = 3'd0,
    FETCH_L = 3'd1,
    FETCH_H = 3'd2,
    DECODE  = 3'd3,
    EXEC    = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);

  localparam logic [OPW-1:0] OP_BRA  = 6'h00;
  localparam logic [OPW-1:0] OP_BNE  = 6'h01;
  localparam logic [OPW-1:0] OP_LDIM = 6'h02;
  localparam logic [OPW-1:0] OP_INC  = 6'h03;
  localparam logic [OPW-1:0] OP_ADD  = 6'h04;
  localparam logic [OPW-1:0] OP_STR  = 6'h05;
  localparam logic [OPW-1:0] OP_HLT  = 6'h3F;

  localparam logic [2:0] FS3_DEC  = 3'd0;
  localparam logic [2:0] FS3_INC  = 3'd1;
  localparam logic [2:0] FS3_LOAD = 3'd2;
  localparam logic [2:0] FS3_CLR  = 3'd3;

  localparam logic [1:0] FS2_DEC  = 2'd0;
  localparam logic [1:0] FS2_INC  = 2'd1;
  localparam logic [1:0] FS2_LOAD = 2'd2;
  localparam logic [1:0] FS2_CLR  = 2'd3;

  localparam logic [4:0] FS5_PASS_A = 5'h00;
  localparam logic [4:0] FS5_ADD    = 5'h04;

  localparam logic [1:0] MUXA_ALU = 2'd0;
  localparam logic [1:0] MUXA_SCR = 2'd1;
  localparam logic [1:0] MUXA_IR  = 2'd2;
  localparam logic [1:0] MUXA_ARF = 2'd3;

  localparam logic [1:0] MUXB_ALU = 2'd0;
  localparam logic [1:0] MUXB_MEM = 2'd1;
  localparam logic [1:0] MUXB_IR  = 2'd2;
  localparam logic [1:0] MUXB_ARF = 2'd3;

  // ARF port selects and active-low {PC,AR,SP} enables
  localparam logic [1:0] ARF_PC    = 2'd0;
  localparam logic [1:0] ARF_SP    = 2'd1;
  localparam logic [1:0] ARF_AR    = 2'd2;
  localparam logic [2:0] ARF_EN_PC = 3'b011;
  localparam logic [2:0] ARF_EN_AR = 3'b101;

  // RF port codes 0-3 are R[0..3], 4-7 are scratch S1..S4
  localparam logic [2:0] OUT_S1    = 3'b100;
  localparam logic [3:0] SCR_EN_S1 = 4'b1110;

  typedef struct packed {
    logic [3:0] regsel_rf;
    logic [3:0] scrsel;
    logic [2:0] funsel3;
    logic [2:0] outasel;
    logic [2:0] outbsel;
    logic       muxdsel;
    logic [4:0] funsel5;
    logic [1:0] muxcsel;
    logic       lh;
    logic       write;
    logic       e;
    logic [1:0] funsel2_dr;
    logic [1:0] muxasel;
    logic [1:0] muxbsel;
    logic [1:0] funsel2_arf;
    logic [2:0] regsel_arf;
    logic [1:0] outcsel;
    logic [1:0] outdsel;
    logic       wr;
    logic       cs;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{regsel_rf: 4'hF, scrsel: 4'hF, regsel_arf: 3'h7,
                                  cs: 1'b1, default: '0};

  // Active-low one-hot enable for RF register sel
  function automatic logic [3:0] rf_en(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of (state, T, opcode, rsel, flags) into the datapath control bundle.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  state_t            state,
  input  logic [STEP_W-1:0] t,
  input  logic [OPW-1:0]    opcode,
  input  logic [1:0]        rsel,
  input  logic [3:0]        flags,
  output ctrl_t             ctrl
);

  // C, N and O are not used by any sequenced instruction
  logic unused_flags;
  assign unused_flags = ^flags[2:0];

  // Moore decode: idle vector first, then per-state overrides
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      CLR_PC: begin
        ctrl.regsel_arf  = ARF_EN_PC;
        ctrl.funsel2_arf = FS2_CLR;
      end
      FETCH_L, FETCH_H: begin
        ctrl.outdsel     = ARF_PC;
        ctrl.cs          = 1'b0;
        ctrl.wr          = 1'b0;
        ctrl.lh          = (state == FETCH_H);
        ctrl.write       = 1'b1;
        ctrl.regsel_arf  = ARF_EN_PC;
        ctrl.funsel2_arf = FS2_INC;
      end
      EXEC: begin
        case (opcode)
          OP_BRA, OP_BNE: begin
            if (t == T0 && (opcode == OP_BRA || !flags[3])) begin
              ctrl.muxbsel     = MUXB_IR;
              ctrl.regsel_arf  = ARF_EN_PC;
              ctrl.funsel2_arf = FS2_LOAD;
            end
          end
          OP_LDIM: begin
            if (t <= T1) begin
              ctrl.muxasel   = MUXA_IR;
              ctrl.regsel_rf = rf_en(rsel);
              ctrl.funsel3   = (t == T0) ? FS3_CLR : FS3_LOAD;
            end
          end
          OP_INC: begin
            if (t == T0) begin
              ctrl.regsel_rf = rf_en(rsel);
              ctrl.funsel3   = FS3_INC;
            end
          end
          OP_ADD: begin
            if (t == T0) begin
              ctrl.outasel = {1'b0, rsel};
              ctrl.funsel5 = FS5_PASS_A;
              ctrl.muxasel = MUXA_ALU;
              ctrl.scrsel  = SCR_EN_S1;
              ctrl.funsel3 = FS3_LOAD;
            end else if (t == T1) begin
              ctrl.outasel   = {1'b0, rsel};
              ctrl.outbsel   = OUT_S1;
              ctrl.funsel5   = FS5_ADD;
              ctrl.muxasel   = MUXA_ALU;
              ctrl.regsel_rf = rf_en(rsel);
              ctrl.funsel3   = FS3_LOAD;
            end
          end
          OP_STR: begin
            if (t == T0) begin
              ctrl.muxbsel     = MUXB_IR;
              ctrl.regsel_arf  = ARF_EN_AR;
              ctrl.funsel2_arf = FS2_LOAD;
            end else if (t == T1) begin
              ctrl.outdsel = ARF_AR;
              ctrl.outasel = {1'b0, rsel};
              ctrl.funsel5 = FS5_PASS_A;
              ctrl.muxcsel = 2'd0;
              ctrl.cs      = 1'b0;
              ctrl.wr      = 1'b1;
            end
          end
          OP_HLT: ;
          default: ctrl.illegal = (t == T0);
        endcase
      end
      HALT:    ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_system_ctrl.sv
// Hardwired multi-cycle sequencer for the alu_system datapath.
// Optional feature: define ALU_CTRL_SINGLE_STEP_EN to add a `step` input that gates FETCH_L.
module alu_system_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
`ifdef ALU_CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [3:0]  RegSel_rf,
  output logic [3:0]  ScrSel,
  output logic [2:0]  FunSel3,
  output logic [2:0]  OutASel,
  output logic [2:0]  OutBSel,
  output logic        MuxDSel,
  output logic [4:0]  FunSel5,
  output logic [1:0]  MuxCSel,
  output logic        LH,
  output logic        write,
  output logic        E,
  output logic [1:0]  FunSel2_dr,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  FunSel2_arf,
  output logic [2:0]  RegSel_arf,
  output logic [1:0]  OutCSel,
  output logic [1:0]  OutDSel,
  output logic        WR,
  output logic        CS,
  output logic        halted,
  output logic        illegal
);

  state_t            state, state_nx;
  logic [STEP_W-1:0] t, t_nx, last_t;
  logic [OPW-1:0]    opcode;
  logic [1:0]        rsel;
  logic              hold;
  ctrl_t             dec_ctrl, ctrl;

  // The immediate byte reaches the datapath straight from the IR
  logic unused_imm;
  assign unused_imm = ^ir[7:0];

`ifdef ALU_CTRL_SINGLE_STEP_EN
  logic step_q;

  // Previous step level for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign hold = (state == FETCH_L) && !(step && !step_q);
`else
  assign hold = 1'b0;
`endif

  // State, step counter and latched IR fields
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= CLR_PC;
      t      <= '0;
      opcode <= '0;
      rsel   <= '0;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      if (state == DECODE) begin
        opcode <= ir[15:10];
        rsel   <= ir[9:8];
      end
    end
  end

  // Next state and step count; two-step ops end at T1, everything else at T0
  always_comb begin
    state_nx = state;
    t_nx     = t;
    last_t   = (opcode == OP_LDIM || opcode == OP_ADD || opcode == OP_STR) ? T1 : T0;
    case (state)
      CLR_PC:  state_nx = FETCH_L;
      FETCH_L: if (!hold) state_nx = FETCH_H;
      FETCH_H: state_nx = DECODE;
      DECODE: begin
        state_nx = EXEC;
        t_nx     = T0;
      end
      EXEC: begin
        if (t > T1) begin
          state_nx = FETCH_L;
          t_nx     = T0;
        end else if (opcode == OP_HLT) begin
          state_nx = HALT;
          t_nx     = T0;
        end else if (t == last_t) begin
          state_nx = FETCH_L;
          t_nx     = T0;
        end else begin
          t_nx = t + STEP_W'(1);
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = CLR_PC;
    endcase
  end

  alu_ctrl_decode u_decode (
    .state  (state),
    .t      (t),
    .opcode (opcode),
    .rsel   (rsel),
    .flags  (flags),
    .ctrl   (dec_ctrl)
  );

  // Reset and a held fetch both present the idle vector
  assign ctrl = (reset || hold) ? CTRL_IDLE : dec_ctrl;

  assign RegSel_rf   = ctrl.regsel_rf;
  assign ScrSel      = ctrl.scrsel;
  assign FunSel3     = ctrl.funsel3;
  assign OutASel     = ctrl.outasel;
  assign OutBSel     = ctrl.outbsel;
  assign MuxDSel     = ctrl.muxdsel;
  assign FunSel5     = ctrl.funsel5;
  assign MuxCSel     = ctrl.muxcsel;
  assign LH          = ctrl.lh;
  assign write       = ctrl.write;
  assign E           = ctrl.e;
  assign FunSel2_dr  = ctrl.funsel2_dr;
  assign MuxASel     = ctrl.muxasel;
  assign MuxBSel     = ctrl.muxbsel;
  assign FunSel2_arf = ctrl.funsel2_arf;
  assign RegSel_arf  = ctrl.regsel_arf;
  assign OutCSel     = ctrl.outcsel;
  assign OutDSel     = ctrl.outdsel;
  assign WR          = ctrl.wr;
  assign CS          = ctrl.cs;
  assign halted      = ctrl.halted;
  assign illegal     = ctrl.illegal;

endmodule

// File: tb/tb_alu_system_ctrl.sv
// Bench for alu_system_ctrl: a small behavioural datapath closes the loop; a scoreboard
// holds the architectural state expected after each instruction.
module tb_alu_system_ctrl;
  import alu_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir;
  logic [3:0]  flags = 4'b1000;
  logic [3:0]  RegSel_rf, ScrSel;
  logic [2:0]  FunSel3, OutASel, OutBSel, RegSel_arf;
  logic        MuxDSel, LH, write, E, WR, CS, halted, illegal;
  logic [4:0]  FunSel5;
  logic [1:0]  MuxCSel, FunSel2_dr, MuxASel, MuxBSel, FunSel2_arf, OutCSel, OutDSel;

  always #5 clock = ~clock;

`ifdef ALU_CTRL_SINGLE_STEP_EN
  logic step, step_tgl = 1'b0, step_man = 1'b0;
  bit   auto_step = 1'b1;
  always @(negedge clock) if (auto_step) step_tgl = ~step_tgl;
  assign step = auto_step ? step_tgl : step_man;
`endif

  alu_system_ctrl dut (
    .clock(clock), .reset(reset), .ir(ir), .flags(flags),
`ifdef ALU_CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .RegSel_rf(RegSel_rf), .ScrSel(ScrSel), .FunSel3(FunSel3), .OutASel(OutASel),
    .OutBSel(OutBSel), .MuxDSel(MuxDSel), .FunSel5(FunSel5), .MuxCSel(MuxCSel), .LH(LH),
    .write(write), .E(E), .FunSel2_dr(FunSel2_dr), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .FunSel2_arf(FunSel2_arf), .RegSel_arf(RegSel_arf), .OutCSel(OutCSel), .OutDSel(OutDSel),
    .WR(WR), .CS(CS), .halted(halted), .illegal(illegal)
  );

  // ---------------- behavioural datapath ----------------
  logic [15:0] pc = 16'hDEAD, ar = 16'h0000, sp = 16'h0000, irr = 16'h0000;
  logic [15:0] r [4];
  logic [15:0] s [4];
  logic [7:0]  mem [256];
  logic [15:0] alu_a, alu_b, alu_y, muxa, muxb, addr;

  assign ir = irr;

  function automatic logic [15:0] rf_rd(input logic [2:0] sel);
    return sel[2] ? s[sel[1:0]] : r[sel[1:0]];
  endfunction

  function automatic logic [15:0] f3(input logic [2:0] fs, input logic [15:0] q, input logic [15:0] d);
    case (fs)
      FS3_CLR:  return 16'h0000;
      FS3_LOAD: return d;
      FS3_INC:  return q + 16'h0001;
      default:  return q - 16'h0001;
    endcase
  endfunction

  function automatic logic [15:0] f2(input logic [1:0] fs, input logic [15:0] q, input logic [15:0] d);
    case (fs)
      FS2_CLR:  return 16'h0000;
      FS2_LOAD: return d;
      FS2_INC:  return q + 16'h0001;
      default:  return q - 16'h0001;
    endcase
  endfunction

  always_comb begin
    alu_a = MuxDSel ? ar : rf_rd(OutASel);
    alu_b = rf_rd(OutBSel);
    alu_y = (FunSel5 == FS5_ADD) ? alu_a + alu_b : alu_a;
    muxa  = (MuxASel == MUXA_IR) ? {8'h00, irr[7:0]} : alu_y;
    muxb  = (MuxBSel == MUXB_IR) ? {8'h00, irr[7:0]} : alu_y;
    addr  = (OutDSel == ARF_AR) ? ar : (OutDSel == ARF_SP) ? sp : pc;
  end

  always @(posedge clock) begin
    if (!CS && !WR && write) begin
      if (LH) irr[15:8] <= mem[addr[7:0]];
      else    irr[7:0]  <= mem[addr[7:0]];
    end
    if (!CS && WR) mem[addr[7:0]] <= (MuxCSel == 2'd0) ? alu_y[7:0] : alu_y[15:8];
    for (int i = 0; i < 4; i++) begin
      if (!RegSel_rf[i]) r[i] <= f3(FunSel3, r[i], muxa);
      if (!ScrSel[i])    s[i] <= f3(FunSel3, s[i], muxa);
    end
    if (!RegSel_arf[2]) pc <= f2(FunSel2_arf, pc, muxb);
    if (!RegSel_arf[1]) ar <= f2(FunSel2_arf, ar, muxb);
    if (!RegSel_arf[0]) sp <= f2(FunSel2_arf, sp, muxb);
  end

  // ---------------- checking ----------------
  int passed = 0, failed = 0, total = 0, ill_cnt = 0;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    int          idx;     // 0-3 R[idx], 4 AR, 5 mem[maddr]
    logic [7:0]  maddr;
    logic [15:0] val;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] epc, input int idx,
                      input logic [7:0] maddr, input logic [15:0] val);
    exp_t e;
    e.tag = tag; e.pc = epc; e.idx = idx; e.maddr = maddr; e.val = val;
    sbq.push_back(e);
  endtask

  // Advance to the next active FETCH_L cycle (bounded), counting illegal pulses on the way
  task automatic wait_fetch(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (illegal) ill_cnt++;
      if (write && !LH) found = 1'b1;
    end
    chk({"fetch_reached ", tag}, 16'(found), 16'h0001);
  endtask

  // Retire one instruction: compare model state with the oldest expectation
  task automatic sb_pop();
    exp_t e;
    logic [15:0] obs;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 16'h0000, 16'h0001);
    end else begin
      e = sbq.pop_front();
      wait_fetch(e.tag);
      if (e.idx < 4)       obs = r[e.idx[1:0]];
      else if (e.idx == 4) obs = ar;
      else                 obs = {8'h00, mem[e.maddr]};
      chk({e.tag, " pc"}, pc, e.pc);
      chk({e.tag, " val"}, obs, e.val);
    end
  endtask

  bit stable;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin r[i] = 16'h0000; s[i] = 16'h0000; end
    // program: LDIM R0,0A; BNE 20; LDIM R1,3; ADD R1; op 2A; STR R1,80; BNE 20; @20 HLT
    mem[0]  = 8'h0A; mem[1]  = 8'h08;
    mem[2]  = 8'h20; mem[3]  = 8'h04;
    mem[4]  = 8'h03; mem[5]  = 8'h09;
    mem[6]  = 8'h00; mem[7]  = 8'h11;
    mem[8]  = 8'h00; mem[9]  = 8'hA8;
    mem[10] = 8'h80; mem[11] = 8'h15;
    mem[12] = 8'h20; mem[13] = 8'h04;
    mem[32] = 8'h00; mem[33] = 8'hFC;
    push("ldim_r0",   16'h0002, 0, 8'h00, 16'h000A);
    push("bne_z1",    16'h0004, 0, 8'h00, 16'h000A);
    push("ldim_r1",   16'h0006, 1, 8'h00, 16'h0003);
    push("add_r1",    16'h0008, 1, 8'h00, 16'h0006);
    push("illegal",   16'h000A, 1, 8'h00, 16'h0006);
    push("str_r1",    16'h000C, 5, 8'h80, 16'h0006);
    push("bne_z0",    16'h0020, 4, 8'h00, 16'h0080);

    repeat (3) @(negedge clock);
    chk("rst RegSel_rf", 16'(RegSel_rf), 16'h000F);
    chk("rst ScrSel", 16'(ScrSel), 16'h000F);
    chk("rst RegSel_arf", 16'(RegSel_arf), 16'h0007);
    chk("rst wr_cs_write", 16'({WR, CS, write, E}), 16'h0004);
    chk("rst halted_illegal", 16'({halted, illegal}), 16'h0000);
    reset = 1'b0;

    wait_fetch("first");
    chk("clr_pc pc", pc, 16'h0000);
    chk("fetch_l lh_write_cs", 16'({LH, write, CS, WR}), 16'h0004);
    @(negedge clock);
    chk("fetch_h lh_write", 16'({LH, write}), 16'h0003);

    sb_pop();  // LDIM R0
    sb_pop();  // BNE with Z=1
    sb_pop();  // LDIM R1
    repeat (4) @(negedge clock);
    chk("add_t1 FunSel5", 16'(FunSel5), 16'(FS5_ADD));
    chk("add_t1 MuxASel", 16'(MuxASel), 16'(MUXA_ALU));
    chk("add_t1 RegSel_rf", 16'(RegSel_rf), 16'h000D);
    sb_pop();  // ADD R1
    ill_cnt = 0;
    sb_pop();  // opcode 2A
    chk("illegal pulse cycles", 16'(ill_cnt), 16'h0001);
    sb_pop();  // STR R1
    flags = 4'b0000;
    sb_pop();  // BNE with Z=0

    stable = 1'b0;
    for (int i = 0; i < 10 && !stable; i++) begin
      @(negedge clock);
      stable = halted;
    end
    chk("halt reached", 16'(stable), 16'h0001);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      stable &= halted && RegSel_rf == 4'hF && ScrSel == 4'hF && RegSel_arf == 3'h7 &&
                !write && !E && CS && !WR && !illegal && pc == 16'h0022;
    end
    chk("halt steady idle", 16'(stable), 16'h0001);

    // reset out of HALT, then abort a STR in its write step
    reset = 1'b1;
    mem[0] = 8'h90; mem[1] = 8'h14;   // STR R0,90
    mem[144] = 8'h5A;
    for (int a = 2; a < 32; a += 2) begin mem[a] = 8'h00; mem[a+1] = 8'h0E; end  // INC R2
    repeat (2) @(negedge clock);
    chk("rst_from_halt halted", 16'(halted), 16'h0000);
    reset = 1'b0;
    stable = 1'b0;
    for (int i = 0; i < 40 && !stable; i++) begin
      @(negedge clock);
      stable = WR;
    end
    chk("str write step reached", 16'(stable), 16'h0001);
    reset = 1'b1;
    #1;
    chk("midstr rst WR", 16'(WR), 16'h0000);
    chk("midstr rst CS", 16'(CS), 16'h0001);
    @(negedge clock);
    chk("midstr no mem write", 16'(mem[144]), 16'h005A);
    reset = 1'b0;
    #1;
    chk("clr_pc RegSel_arf", 16'(RegSel_arf), 16'(ARF_EN_PC));
    chk("clr_pc FunSel2_arf", 16'(FunSel2_arf), 16'(FS2_CLR));
    wait_fetch("after_abort");
    chk("pc cleared after abort", pc, 16'h0000);

    push("str_r0",   16'h0002, 5, 8'h90, 16'h000A);
    push("inc_r2_a", 16'h0004, 2, 8'h00, 16'h0001);
    push("inc_r2_b", 16'h0006, 2, 8'h00, 16'h0002);
    sb_pop();
    sb_pop();
    sb_pop();

`ifdef ALU_CTRL_SINGLE_STEP_EN
    auto_step = 1'b0;
    step_man  = 1'b0;
    repeat (50) @(negedge clock);
    chk("step held pc", pc, 16'h0008);
    chk("step held r2", r[2], 16'h0003);
    step_man = 1'b1;
    @(negedge clock);
    step_man = 1'b0;
    repeat (30) @(negedge clock);
    chk("one step pc", pc, 16'h000A);
    chk("one step r2", r[2], 16'h0004);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
